rr_demux: RTL

RR_DEMUX -- requirements
Module: rr_demux

---
 rtl/rr_demux.sv | 136 +++++++++++++
 1 files changed

// File: rtl/rr_demux.sv
// Demultiplexes one arbitrated word stream into four independent destination FIFOs
// with registered per-destination read ports, status flags and sticky error bits.
module rr_demux #(
  parameter int DW    = 5,
  parameter int DEPTH = 4,
  parameter int AF_TH = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid,
  input  logic [DW-1:0]   data_in,
  input  logic [1:0]      dest_id,
  input  logic [3:0]      pop,
  output logic [4*DW-1:0] data_out,
  output logic [3:0]      valid_out,
  output logic [3:0]      empty,
  output logic [3:0]      full,
  output logic [3:0]      almost_full,
  output logic            pause,
  output logic [3:0]      err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AF   = CW'(AF_TH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [AW-1:0] wr_ptr_q [4];
  logic [AW-1:0] wr_ptr_d [4];
  logic [AW-1:0] rd_ptr_q [4];
  logic [AW-1:0] rd_ptr_d [4];
  logic [CW-1:0] cnt_q    [4];
  logic [CW-1:0] cnt_d    [4];
  logic [DW-1:0] dout_q   [4];
  logic [DW-1:0] dout_d   [4];
  logic [3:0]    vout_q, vout_d;
  logic [3:0]    err_q, err_d;

  logic [DW-1:0] mem_q [4][DEPTH];

  logic [3:0] push_hit, is_empty, is_full, do_pop, do_push;

  // A pop only happens on a non-empty FIFO, so a push to a full FIFO is legal
  // exactly when that FIFO pops on the same edge (the freed slot is reused).
  always_comb begin
    push_hit = '0;
    is_empty = '0;
    is_full  = '0;
    do_pop   = '0;
    do_push  = '0;
    for (int i = 0; i < 4; i++) begin
      push_hit[i] = valid && (dest_id == 2'(i));
      is_empty[i] = (cnt_q[i] == CNT_ZERO);
      is_full[i]  = (cnt_q[i] == CNT_FULL);
      do_pop[i]   = pop[i] && !is_empty[i];
      do_push[i]  = push_hit[i] && (!is_full[i] || do_pop[i]);
    end
  end

  always_comb begin
    vout_d = '0;
    err_d  = err_q;
    for (int i = 0; i < 4; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      cnt_d[i]    = cnt_q[i];
      dout_d[i]   = dout_q[i];

      if (do_push[i]) wr_ptr_d[i] = wr_ptr_q[i] + PTR_ONE;
      if (do_pop[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + PTR_ONE;
        dout_d[i]   = mem_q[i][rd_ptr_q[i]];
        vout_d[i]   = 1'b1;
      end

      case ({do_push[i], do_pop[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CNT_ONE;
        2'b01:   cnt_d[i] = cnt_q[i] - CNT_ONE;
        default: cnt_d[i] = cnt_q[i];
      endcase

      if ((push_hit[i] && is_full[i] && !do_pop[i]) || (pop[i] && is_empty[i]))
        err_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
        dout_q[i]   <= '0;
      end
      vout_q <= '0;
      err_q  <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
        dout_q[i]   <= dout_d[i];
      end
      vout_q <= vout_d;
      err_q  <= err_d;
    end
  end

  // Storage is not reset; the counts alone decide which entries are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (do_push[i]) mem_q[i][wr_ptr_q[i]] <= data_in;
    end
  end

  always_comb begin
    data_out    = '0;
    empty       = '0;
    full        = '0;
    almost_full = '0;
    for (int i = 0; i < 4; i++) begin
      data_out[i*DW +: DW] = dout_q[i];
      empty[i]             = (cnt_q[i] == CNT_ZERO);
      full[i]              = (cnt_q[i] == CNT_FULL);
      almost_full[i]       = (cnt_q[i] >= CNT_AF);
    end
    pause = |almost_full;
  end

  assign valid_out = vout_q;
  assign err       = err_q;

endmodule
